// File: rtl/receiver.sv
// Serial-line receiver: 8N1 frames on din, oversampled by sample_en strobes.
// Presents each good byte with a one-cycle rx_status pulse, or flags a bad
// stop bit with a one-cycle rx_err pulse.
module receiver #(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    input  logic       sample_en,
    output logic [7:0] rx_data,
    output logic       rx_status,
    output logic       rx_err
);

    localparam int unsigned CntW = $clog2(OVERSAMPLE);
    localparam logic [CntW-1:0] CntHalf = CntW'(OVERSAMPLE / 2 - 1);
    localparam logic [CntW-1:0] CntLast = CntW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bitn_q, bitn_d;
    logic [7:0]      shreg_q, shreg_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_status_q, rx_status_d;
    logic            rx_err_q, rx_err_d;
    logic            din_meta_q, din_s_q;

    // Two-flop synchronizer; flops reset to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            din_meta_q <= 1'b1;
            din_s_q    <= 1'b1;
        end else begin
            din_meta_q <= din;
            din_s_q    <= din_meta_q;
        end
    end

    // Frame FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bitn_q      <= '0;
            shreg_q     <= '0;
            rx_data_q   <= '0;
            rx_status_q <= 1'b0;
            rx_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bitn_q      <= bitn_d;
            shreg_q     <= shreg_d;
            rx_data_q   <= rx_data_d;
            rx_status_q <= rx_status_d;
            rx_err_q    <= rx_err_d;
        end
    end

    // Next-state logic; everything advances only on sample_en strobes.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bitn_d      = bitn_q;
        shreg_d     = shreg_q;
        rx_data_d   = rx_data_q;
        rx_status_d = 1'b0;
        rx_err_d    = 1'b0;

        if (sample_en) begin
            unique case (state_q)
                StIdle: begin
                    if (!din_s_q) begin
                        state_d = StStart;
                        cnt_d   = '0;
                    end
                end
                StStart: begin
                    if (cnt_q == CntHalf) begin
                        cnt_d = '0;
                        if (!din_s_q) begin
                            state_d = StData;
                            bitn_d  = '0;
                        end else begin
                            // Start bit did not hold to its midpoint: glitch.
                            state_d = StIdle;
                        end
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                StData: begin
                    if (cnt_q == CntLast) begin
                        shreg_d = {din_s_q, shreg_q[7:1]};
                        cnt_d   = '0;
                        bitn_d  = bitn_q + 3'd1;
                        if (bitn_q == 3'd7) begin
                            state_d = StStop;
                        end
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                StStop: begin
                    if (cnt_q == CntLast) begin
                        cnt_d = '0;
                        if (din_s_q) begin
                            rx_data_d   = shreg_q;
                            rx_status_d = 1'b1;
                            state_d     = StIdle;
                        end else begin
                            rx_err_d = 1'b1;
                            state_d  = StBreak;
                        end
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                StBreak: begin
                    // Hold off until the line returns high so a stuck-low
                    // line cannot retrigger frames.
                    if (din_s_q) begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_status = rx_status_q;
    assign rx_err    = rx_err_q;

endmodule

// File: tb/tb_receiver.sv
// Bench for receiver: drives 8N1 frames on din and checks every rx pulse
// against a queue of expected events built from the frames sent.
module tb_receiver;

    localparam int unsigned OS = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din = 1'b1;
    logic       sample_en = 1'b0;
    logic [7:0] rx_data;
    logic       rx_status;
    logic       rx_err;

    int checks = 0;
    int errors = 0;
    int div = 4;
    int se_cnt = 0;
    int cyc = 0;
    int status_cyc = -1;

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] last_good = 8'h00;

    receiver #(.OVERSAMPLE(OS)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .sample_en (sample_en),
        .rx_data   (rx_data),
        .rx_status (rx_status),
        .rx_err    (rx_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe generator: sample_en high one clk in every div.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (se_cnt + 1 >= div) se_cnt = 0;
            else se_cnt = se_cnt + 1;
            sample_en = (se_cnt == 0);
        end
    end

    // Pulse monitor: each pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (rx_status || rx_err) begin
            ev_t ev;
            checks++;
            assert (!(rx_status && rx_err)) else begin
                errors++;
                $error("FAIL pulse_overlap status=%b err=%b required not both", rx_status, rx_err);
            end
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_pulse status=%b err=%b data=%02h required no pulse",
                       rx_status, rx_err, rx_data);
            end
            if (exp_q.size() > 0) begin
                ev = exp_q.pop_front();
                checks++;
                assert (rx_err === ev.err && rx_status === !ev.err && rx_data === ev.data) else begin
                    errors++;
                    $error("FAIL rx_event got err=%b data=%02h required err=%b data=%02h",
                           rx_err, rx_data, ev.err, ev.data);
                end
            end
            if (rx_status) status_cyc = cyc;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        din = b;
        tick(OS * div);
    endtask

    // Model: a good stop bit yields the byte; a bad one yields an error
    // with rx_data still showing the last good byte.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        if (stop) begin
            exp_q.push_back({1'b0, d});
            last_good = d;
        end else begin
            exp_q.push_back({1'b1, last_good});
        end
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() > 0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL %s_pending got %0d required 0", tag, exp_q.size());
        end
        checks++;
        assert (rx_data === last_good) else begin
            errors++;
            $error("FAIL %s_hold got %02h required %02h", tag, rx_data, last_good);
        end
    endtask

    initial begin
        int         t0;
        int         lat;
        logic [7:0] part;

        // Reset values.
        rst = 1'b1;
        tick(4);
        checks++;
        assert (rx_data === 8'h00) else begin
            errors++; $error("FAIL reset_data got %02h required 00", rx_data);
        end
        checks++;
        assert (rx_status === 1'b0) else begin
            errors++; $error("FAIL reset_status got %b required 0", rx_status);
        end
        checks++;
        assert (rx_err === 1'b0) else begin
            errors++; $error("FAIL reset_err got %b required 0", rx_err);
        end
        rst = 1'b0;
        tick(8);

        // Single byte with latency window: about 9.5*OS strobes + 3 clk.
        div = 4;
        tick(8);
        status_cyc = -1;
        t0 = cyc;
        send_frame(8'hA5, 1'b1);
        drain("single");
        lat = status_cyc - t0;
        checks++;
        assert (lat >= (19 * OS / 2) * div + 2 && lat <= (19 * OS / 2) * div + div + 4) else begin
            errors++;
            $error("FAIL latency got %0d required %0d..%0d", lat,
                   (19 * OS / 2) * div + 2, (19 * OS / 2) * div + div + 4);
        end

        // Back-to-back frames, only the stop bit between them.
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h3C, 1'b1);
        drain("b2b");

        // Glitch shorter than half a bit, then a real frame.
        din = 1'b0;
        tick(4 * div);
        din = 1'b1;
        tick(2 * OS * div);
        drain("glitch");
        send_frame(8'h5A, 1'b1);
        drain("after_glitch");

        // Framing error with the line held low, then a good frame.
        send_frame(8'h81, 1'b0);
        tick(40 * div);
        din = 1'b1;
        tick(OS * div);
        drain("framing");
        send_frame(8'h81, 1'b1);
        drain("after_framing");

        // Reset in the middle of data bit 4; the partial frame is abandoned.
        part = 8'h96;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(part[i]);
        din = part[4];
        tick(OS * div / 2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        last_good = 8'h00;
        checks++;
        assert (rx_data === 8'h00 && rx_status === 1'b0 && rx_err === 1'b0) else begin
            errors++;
            $error("FAIL midframe_reset got data=%02h st=%b err=%b required 00/0/0",
                   rx_data, rx_status, rx_err);
        end
        din = 1'b1;
        tick(2 * OS * div);
        drain("reset_idle");
        send_frame(8'hC3, 1'b1);
        drain("after_reset");

        // Random bytes at random strobe rates and idle gaps.
        for (int g = 0; g < 6; g++) begin
            div = $urandom_range(1, 4);
            tick(8);
            for (int k = 0; k < 4; k++) begin
                send_frame(8'($urandom_range(0, 255)), 1'b1);
                tick($urandom_range(0, 20));
            end
            drain("random");
        end

        // Full-rate run: sample_en held high, 16 clk per bit, all byte values.
        div = 1;
        tick(10);
        for (int b = 0; b < 256; b++) send_frame(8'(b), 1'b1);
        drain("full_rate");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
